// File: rtl/ras_circular_stack_if.sv
// ras_circular_stack_if: push/pop/flush/checkpoint request bus and top-of-stack prediction for the return-address stack
interface ras_circular_stack_if #(
    parameter int VLEN = 32
);
    logic            flush_i;
    logic            push_i;
    logic            pop_i;
    logic [VLEN-1:0] data_i;
    logic            ckpt_i;
    logic            restore_i;
    logic            valid_o;
    logic [VLEN-1:0] data_o;

    modport master (
        output flush_i, push_i, pop_i, data_i, ckpt_i, restore_i,
        input  valid_o, data_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, data_i, ckpt_i, restore_i,
        output valid_o, data_o
    );
endinterface

// File: rtl/ras_circular_stack.sv
// ras_circular_stack: circular return-address stack; overflow overwrites the oldest entry; optional snapshot/rollback via RAS_CHECKPOINT_EN
module ras_circular_stack #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    ras_circular_stack_if.slave bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [VLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   tos, tos_n, tos_inc, tos_dec, wa;
    logic [CW-1:0]   cnt, cnt_n;
    logic            we;
    logic [VLEN-1:0] wd, top_n;

    assign tos_inc     = (tos == PW'(DEPTH - 1)) ? '0 : tos + 1'b1;
    assign tos_dec     = (tos == '0) ? PW'(DEPTH - 1) : tos - 1'b1;
    assign bus.valid_o = cnt != '0;
    assign bus.data_o  = mem[tos];
    assign top_n       = (we && wa == tos_n) ? wd : mem[tos_n];

`ifdef RAS_CHECKPOINT_EN
    logic [PW-1:0]   sh_tos;
    logic [CW-1:0]   sh_cnt;
    logic [VLEN-1:0] sh_data;

    // Snapshot the post-update top; a simultaneous restore leaves the snapshot alone
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_tos  <= '0;
            sh_cnt  <= '0;
            sh_data <= '0;
        end else if (bus.ckpt_i && !bus.restore_i) begin
            sh_tos  <= tos_n;
            sh_cnt  <= cnt_n;
            sh_data <= top_n;
        end
    end
`else
    logic unused_ckpt;
    assign unused_ckpt = bus.ckpt_i ^ bus.restore_i;
`endif

    // Next pointer/count and the single memory write: flush, then restore, then push/pop
    always_comb begin
        tos_n = tos;
        cnt_n = cnt;
        we    = 1'b0;
        wa    = tos;
        wd    = bus.data_i;
        if (bus.flush_i) begin
            tos_n = '0;
            cnt_n = '0;
        end
`ifdef RAS_CHECKPOINT_EN
        else if (bus.restore_i) begin
            tos_n = sh_tos;
            cnt_n = sh_cnt;
            we    = 1'b1;
            wa    = sh_tos;
            wd    = sh_data;
        end
`endif
        else if (bus.push_i && (!bus.pop_i || cnt == '0)) begin
            tos_n = tos_inc;
            cnt_n = (cnt == CW'(DEPTH)) ? cnt : cnt + 1'b1;
            we    = 1'b1;
            wa    = tos_inc;
        end else if (bus.push_i) begin
            we    = 1'b1;
        end else if (bus.pop_i && cnt != '0) begin
            tos_n = tos_dec;
            cnt_n = cnt - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos <= '0;
            cnt <= '0;
        end else begin
            tos <= tos_n;
            cnt <= cnt_n;
        end
    end

    // Entry storage; stale entries stay in place after pops and flushes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end
endmodule

// File: tb/tb_ras_circular_stack.sv
// tb_ras_circular_stack: directed and randomized checks of ras_circular_stack against a circular-buffer reference model
module tb_ras_circular_stack;
    localparam int D = 2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    ras_circular_stack_if #(.VLEN(32)) bus ();

    ras_circular_stack #(.DEPTH(D), .VLEN(32)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m [D];
    int          top, n;
    logic [31:0] s_d;
    int          s_top, s_n;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference model: physical slots, top index and occupancy updated from the sampled requests
    initial begin
        top = 0; n = 0; s_top = 0; s_n = 0; s_d = 0;
        for (int i = 0; i < D; i++) m[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                top = 0; n = 0; s_top = 0; s_n = 0; s_d = 0;
                for (int i = 0; i < D; i++) m[i] = 0;
            end else begin
                if (bus.flush_i) begin
                    top = 0; n = 0;
                end
`ifdef RAS_CHECKPOINT_EN
                else if (bus.restore_i) begin
                    top = s_top; n = s_n; m[s_top] = s_d;
                end
`endif
                else if (bus.push_i && (!bus.pop_i || n == 0)) begin
                    top = (top + 1) % D;
                    m[top] = bus.data_i;
                    n = (n < D) ? n + 1 : D;
                end else if (bus.push_i) begin
                    m[top] = bus.data_i;
                end else if (bus.pop_i && n > 0) begin
                    top = (top + D - 1) % D;
                    n = n - 1;
                end
`ifdef RAS_CHECKPOINT_EN
                if (bus.ckpt_i && !bus.restore_i) begin
                    s_top = top; s_n = n; s_d = m[top];
                end
`endif
            end
        end
    end

    // Compare process: outputs against the model every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", {31'b0, bus.valid_o}, {31'b0, n != 0});
            chk("model_data", bus.data_o, m[top]);
        end
    end

    task automatic step(input logic f, input logic p, input logic q, input logic [31:0] d,
                        input logic c, input logic r);
        bus.flush_i = f; bus.push_i = p; bus.pop_i = q; bus.data_i = d;
        bus.ckpt_i = c; bus.restore_i = r;
        @(posedge clk);
        #1;
        bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.data_i = 0;
        bus.ckpt_i = 0; bus.restore_i = 0;
    endtask

    task automatic push(input logic [31:0] d);
        step(0, 1, 0, d, 0, 0);
    endtask

    task automatic pop();
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic flush();
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0;
        bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.data_i = 0;
        bus.ckpt_i = 0; bus.restore_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        #1;
        chk("reset_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("reset_data", bus.data_o, 32'd0);

        bus.pop_i = 1;
        #1;
        chk("t1_pop_empty_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("t1_pop_empty_data", bus.data_o, 32'd0);
        @(posedge clk);
        #1;
        bus.pop_i = 0;
        chk("t1_after_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("t1_after_data", bus.data_o, 32'd0);

        push(32'h8000_0010);
        push(32'h8000_0020);
        chk("t2_top", bus.data_o, 32'h8000_0020);
        pop();
        chk("t2_pop1_data", bus.data_o, 32'h8000_0010);
        chk("t2_pop1_valid", {31'b0, bus.valid_o}, 32'd1);
        pop();
        chk("t2_pop2_valid", {31'b0, bus.valid_o}, 32'd0);

        flush();
        push(32'h100);
        push(32'h200);
        push(32'h300);
        chk("t3_overflow_top", bus.data_o, 32'h300);
        pop();
        chk("t3_pop1_data", bus.data_o, 32'h200);
        chk("t3_pop1_valid", {31'b0, bus.valid_o}, 32'd1);
        pop();
        chk("t3_oldest_gone", {31'b0, bus.valid_o}, 32'd0);

        flush();
        push(32'h100);
        step(0, 1, 1, 32'h500, 0, 0);
        chk("t4_swap_data", bus.data_o, 32'h500);
        chk("t4_swap_valid", {31'b0, bus.valid_o}, 32'd1);
        pop();
        chk("t4_cnt_one", {31'b0, bus.valid_o}, 32'd0);

        step(0, 1, 1, 32'h600, 0, 0);
        chk("t4_swap_empty_data", bus.data_o, 32'h600);
        chk("t4_swap_empty_valid", {31'b0, bus.valid_o}, 32'd1);

        flush();
        push(32'h100);
        step(1, 1, 0, 32'h900, 0, 0);
        chk("t5_flush_wins", {31'b0, bus.valid_o}, 32'd0);

        push(32'h100);
        chk("t5_pre_reset_valid", {31'b0, bus.valid_o}, 32'd1);
        @(negedge clk);
        bus.push_i = 1; bus.data_i = 32'h200;
        #2 rst_n = 0;
        #1;
        chk("t5_async_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("t5_async_data", bus.data_o, 32'd0);
        bus.push_i = 0; bus.data_i = 0;
        @(negedge clk) rst_n = 1;
        #1;
        chk("t5_post_reset_valid", {31'b0, bus.valid_o}, 32'd0);

        push(32'h100);
        step(0, 0, 0, 0, 1, 0);
        pop();
        push(32'h700);
        step(0, 0, 0, 0, 0, 1);
`ifdef RAS_CHECKPOINT_EN
        chk("t6_restore_data", bus.data_o, 32'h100);
`else
        chk("t6_restore_data", bus.data_o, 32'h700);
`endif
        chk("t6_restore_valid", {31'b0, bus.valid_o}, 32'd1);

`ifdef RAS_CHECKPOINT_EN
        rst_n = 0;
        #1 rst_n = 1;
        step(0, 0, 0, 0, 0, 1);
        chk("t6_restore_no_ckpt", {31'b0, bus.valid_o}, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
